hmc_mem_link_tx_init: RTL and testbench

Device-side (HMC memory model) transmit link sequencer. It drives phy_data_rx_phy2link toward the controller's PHY input. The power-on/initialization sequence is NULL → TS1 → NULL → TRET token return, then response flits are passed through in ACTIVE. It is the transmit counterpart of the memory-side receive path: it answers the controller's P_RST_N/LXRXPS handshake with LXTXPS and signals fatal init errors on FERR_N.

---
 rtl/hmc_mem_pkg.sv | 52 +++++
 rtl/hmc_mem_ts1_gen.sv | 38 +++
 rtl/hmc_mem_link_tx_init.sv | 153 +++++++++++++++
 tb/tb_hmc_mem_link_tx_init.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmc_mem_pkg.sv
// Shared types and flit builders for the HMC device-side transmit link init.
// Flit layout: header in [63:0] (CMD, LNG, DLN), tail in [127:64] (SEQ, RTC, CRC).
package hmc_mem_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_RXPS,
        ST_NULL1,
        ST_TS1,
        ST_NULL2,
        ST_TRET,
        ST_ACTIVE,
        ST_ERROR
    } state_t;

    localparam int          FLIT_W      = 128;
    localparam logic [5:0]  CMD_TRET    = 6'h02;
    localparam int          MAX_RTC     = 31;
    localparam logic [31:0] CRC32K_POLY = 32'h741B8CD7;

    function automatic logic [15:0] ts1_word(input logic [3:0] seq);
        return {4'hF, 4'h0, 4'h3, seq};
    endfunction

    // MSB-first CRC-32K over the whole flit; the CRC field must be zero on entry.
    function automatic logic [31:0] crc32k_flit(input logic [FLIT_W-1:0] flit);
        logic [31:0] crc;
        logic        fb;
        crc = '0;
        for (int i = FLIT_W - 1; i >= 0; i--) begin
            fb  = crc[31] ^ flit[i];
            crc = {crc[30:0], 1'b0};
            if (fb) begin
                crc = crc ^ CRC32K_POLY;
            end
        end
        return crc;
    endfunction

    function automatic logic [FLIT_W-1:0] make_tret(input logic [4:0] rtc, input logic [2:0] seq);
        logic [FLIT_W-1:0] f;
        f          = '0;
        f[5:0]     = CMD_TRET;
        f[10:7]    = 4'd1;
        f[14:11]   = 4'd1;
        f[82:80]   = seq;
        f[95:91]   = rtc;
        f[127:96]  = crc32k_flit(f);
        return f;
    endfunction

endpackage

// File: rtl/hmc_mem_ts1_gen.sv
// TS1 lane-word generator: every lane carries the same run of ts1_word(seq), seq advancing
// LW/16 words per enabled cycle; output is combinational from the registered seq.
module hmc_mem_ts1_gen
    import hmc_mem_pkg::*;
#(
    parameter int DWIDTH    = 256,
    parameter int NUM_LANES = 8
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              clear,
    input  logic              enable,
    output logic [DWIDTH-1:0] lane_words
);

    localparam int LW             = DWIDTH / NUM_LANES;
    localparam int WORDS_PER_LANE = LW / 16;

    logic [3:0] seq;

    always_ff @(posedge clk) begin
        if (!res_n || clear) begin
            seq <= '0;
        end else if (enable) begin
            seq <= seq + 4'(WORDS_PER_LANE);
        end
    end

    always_comb begin
        lane_words = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int w = 0; w < WORDS_PER_LANE; w++) begin
                lane_words[l*LW + w*16 +: 16] = ts1_word(seq + 4'(w));
            end
        end
    end

endmodule

// File: rtl/hmc_mem_link_tx_init.sv
// Device TX link sequencer: NULL -> TS1 -> NULL -> TRET, then response flit pass-through.
// All outputs registered; pass-through latency 1 cycle, ready held high only in ACTIVE.
module hmc_mem_link_tx_init
    import hmc_mem_pkg::*;
#(
    parameter int DWIDTH        = 256,
    parameter int NUM_LANES     = 8,
    parameter int T_NULL_CYC    = 55,
    parameter int T_TRET_CYC    = 55,
    parameter int TS1_TIMEOUT   = 4096,
    parameter int RETURN_TOKENS = 64
) (
    input  logic              hmc_clk,
    input  logic              hmc_res_n,
    input  logic              P_RST_N,
    input  logic              LXRXPS,
    output logic              LXTXPS,
    output logic              FERR_N,
    input  logic              ts1_locked,
    input  logic [DWIDTH-1:0] tx_flit_data,
    input  logic              tx_flit_valid,
    output logic              tx_flit_ready,
    output logic [DWIDTH-1:0] phy_data_rx_phy2link,
    output logic              init_done
);

    localparam int FLITS_PER_CYC = DWIDTH / FLIT_W;
    localparam int CNT_W         = $clog2(TS1_TIMEOUT + T_NULL_CYC + T_TRET_CYC + 1);
    localparam int TOK_RAW_W     = $clog2(RETURN_TOKENS + 2);
    localparam int TOK_W         = (TOK_RAW_W < 6) ? 6 : TOK_RAW_W;

    localparam logic [CNT_W-1:0] NULL1_LAST = CNT_W'(T_NULL_CYC - 1);
    localparam logic [CNT_W-1:0] NULL2_LAST = CNT_W'(T_TRET_CYC - 1);
    localparam logic [CNT_W-1:0] TS1_LAST   = CNT_W'(TS1_TIMEOUT - 1);
    localparam logic [TOK_W-1:0] TOK_TOTAL  = TOK_W'(RETURN_TOKENS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TOK_W-1:0]  sent_q, sent_d, tok_left;
    logic [2:0]        tseq_q, tseq_d;
    logic [4:0]        rtc;
    logic [DWIDTH-1:0] ts1_words, tret_data, data_d;
    logic              lxtxps_d;
    logic              ts1_run;

    assign ts1_run = (state_d == ST_TS1);

    hmc_mem_ts1_gen #(
        .DWIDTH    (DWIDTH),
        .NUM_LANES (NUM_LANES)
    ) u_ts1_gen (
        .clk        (hmc_clk),
        .res_n      (hmc_res_n),
        .clear      (!ts1_run),
        .enable     (ts1_run),
        .lane_words (ts1_words)
    );

    // cnt_q counts cycles already spent in the current timed state.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (!P_RST_N) begin
            state_d = ST_RESET;
        end else if (!LXRXPS && (state_q inside {ST_NULL1, ST_TS1, ST_NULL2, ST_TRET, ST_ACTIVE})) begin
            state_d = ST_WAIT_RXPS;
        end else begin
            case (state_q)
                ST_RESET:     state_d = ST_WAIT_RXPS;
                ST_WAIT_RXPS: if (LXRXPS) state_d = ST_NULL1;
                ST_NULL1: begin
                    if (cnt_q == NULL1_LAST) state_d = ST_TS1;
                    else                     cnt_d   = cnt_q + 1'b1;
                end
                ST_TS1: begin
                    if (ts1_locked)             state_d = ST_NULL2;
                    else if (cnt_q == TS1_LAST) state_d = ST_ERROR;
                    else                        cnt_d   = cnt_q + 1'b1;
                end
                ST_NULL2: begin
                    if (cnt_q == NULL2_LAST) state_d = (RETURN_TOKENS == 0) ? ST_ACTIVE : ST_TRET;
                    else                     cnt_d   = cnt_q + 1'b1;
                end
                ST_TRET:      if (sent_q == TOK_TOTAL) state_d = ST_ACTIVE;
                default:      state_d = state_q;
            endcase
        end
    end

    // Builds the TRET flits for the cycle being loaded; sent_q counts tokens already on the wire.
    always_comb begin
        tok_left  = TOK_TOTAL - sent_q;
        sent_d    = '0;
        tseq_d    = '0;
        rtc       = '0;
        tret_data = '0;
        if (state_d == ST_TRET) begin
            sent_d = sent_q;
            tseq_d = tseq_q;
            for (int s = 0; s < FLITS_PER_CYC; s++) begin
                if (tok_left != '0) begin
                    rtc = (tok_left > TOK_W'(MAX_RTC)) ? 5'(MAX_RTC) : tok_left[4:0];
                    tret_data[s*FLIT_W +: FLIT_W] = make_tret(rtc, tseq_d);
                    tok_left = tok_left - TOK_W'(rtc);
                    sent_d   = sent_d + TOK_W'(rtc);
                    tseq_d   = tseq_d + 3'd1;
                end
            end
        end
    end

    always_comb begin
        data_d   = '0;
        lxtxps_d = 1'b0;
        case (state_d)
            ST_TS1:    data_d = ts1_words;
            ST_TRET:   data_d = tret_data;
            // A flit accepted in the same cycle the link drops is discarded.
            ST_ACTIVE: data_d = (state_q == ST_ACTIVE && tx_flit_valid && tx_flit_ready) ? tx_flit_data : '0;
            default:   data_d = '0;
        endcase
        case (state_d)
            ST_NULL1, ST_TS1, ST_NULL2, ST_TRET, ST_ACTIVE: lxtxps_d = 1'b1;
            ST_ERROR: lxtxps_d = LXTXPS;
            default:  lxtxps_d = 1'b0;
        endcase
    end

    always_ff @(posedge hmc_clk) begin
        if (!hmc_res_n) begin
            state_q              <= ST_RESET;
            cnt_q                <= '0;
            sent_q               <= '0;
            tseq_q               <= '0;
            LXTXPS               <= 1'b0;
            FERR_N               <= 1'b1;
            tx_flit_ready        <= 1'b0;
            init_done            <= 1'b0;
            phy_data_rx_phy2link <= '0;
        end else begin
            state_q              <= state_d;
            cnt_q                <= cnt_d;
            sent_q               <= sent_d;
            tseq_q               <= tseq_d;
            LXTXPS               <= lxtxps_d;
            FERR_N               <= (state_d != ST_ERROR);
            tx_flit_ready        <= (state_d == ST_ACTIVE);
            init_done            <= (state_d == ST_ACTIVE);
            phy_data_rx_phy2link <= data_d;
        end
    end

endmodule

// File: tb/tb_hmc_mem_link_tx_init.sv
// Bench for the device TX link sequencer: init sequence, pass-through, link drop, reset, TS1 timeout.
module tb_hmc_mem_link_tx_init;

    localparam int DW     = 256;
    localparam int NL     = 8;
    localparam int LW     = DW / NL;
    localparam int WPL    = LW / 16;
    localparam int FPC    = DW / 128;
    localparam int T_NULL = 55;
    localparam int T_TRET = 55;
    localparam int TO     = 4096;
    localparam int TOK    = 64;

    logic          hmc_clk = 1'b0;
    logic          hmc_res_n, P_RST_N, LXRXPS, ts1_locked, tx_flit_valid;
    logic [DW-1:0] tx_flit_data;
    logic          LXTXPS, FERR_N, tx_flit_ready, init_done;
    logic [DW-1:0] phy_data_rx_phy2link;

    int            vectors = 0;
    int            errors  = 0;
    logic [DW-1:0] tret_q[$];

    always #5 hmc_clk = ~hmc_clk;

    hmc_mem_link_tx_init #(
        .DWIDTH(DW), .NUM_LANES(NL), .T_NULL_CYC(T_NULL), .T_TRET_CYC(T_TRET),
        .TS1_TIMEOUT(TO), .RETURN_TOKENS(TOK)
    ) dut (
        .hmc_clk              (hmc_clk),
        .hmc_res_n            (hmc_res_n),
        .P_RST_N              (P_RST_N),
        .LXRXPS               (LXRXPS),
        .LXTXPS               (LXTXPS),
        .FERR_N               (FERR_N),
        .ts1_locked           (ts1_locked),
        .tx_flit_data         (tx_flit_data),
        .tx_flit_valid        (tx_flit_valid),
        .tx_flit_ready        (tx_flit_ready),
        .phy_data_rx_phy2link (phy_data_rx_phy2link),
        .init_done            (init_done)
    );

    task automatic step();
        @(posedge hmc_clk);
        #1;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // k-th TS1 cycle: the stream of words on each lane is F030, F031, ... counted from TS1 entry.
    function automatic logic [DW-1:0] exp_ts1(input int k);
        logic [DW-1:0] v;
        v = '0;
        for (int l = 0; l < NL; l++)
            for (int j = 0; j < WPL; j++)
                v[l*LW + j*16 +: 16] = 16'hF030 + 16'((k * WPL + j) % 16);
        return v;
    endfunction

    // CRC as polynomial long division of flit * x^32 by the CRC-32K generator.
    function automatic logic [127:0] tb_tret(input int rtc, input int seq);
        logic [127:0] f;
        logic [159:0] r;
        f         = '0;
        f[5:0]    = 6'h02;
        f[10:7]   = 4'd1;
        f[14:11]  = 4'd1;
        f[82:80]  = 3'(seq % 8);
        f[95:91]  = 5'(rtc);
        r = {f, 32'h0};
        for (int i = 159; i >= 32; i--)
            if (r[i]) r[i -: 33] = r[i -: 33] ^ {1'b1, 32'h741B8CD7};
        f[127:96] = r[31:0];
        return f;
    endfunction

    task automatic build_tret();
        int rem, seq, slot, rtc;
        logic [DW-1:0] cyc;
        tret_q.delete();
        rem = TOK; seq = 0; slot = 0; cyc = '0;
        while (rem > 0) begin
            rtc = (rem > 31) ? 31 : rem;
            cyc[slot*128 +: 128] = tb_tret(rtc, seq);
            rem -= rtc; seq++; slot++;
            if (slot == FPC || rem == 0) begin
                tret_q.push_back(cyc);
                cyc  = '0;
                slot = 0;
            end
        end
    endtask

    task automatic test_reset();
        hmc_res_n = 1'b0; P_RST_N = 1'b1; LXRXPS = 1'b1; ts1_locked = 1'b1;
        tx_flit_valid = 1'b1; tx_flit_data = rand_data();
        advance(3);
        vectors++; if (LXTXPS !== 1'b0) begin errors++; $display("FAIL rst_lxtxps got %b exp 0", LXTXPS); end
        vectors++; if (FERR_N !== 1'b1) begin errors++; $display("FAIL rst_ferr_n got %b exp 1", FERR_N); end
        vectors++; if (tx_flit_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", tx_flit_ready); end
        vectors++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b exp 0", init_done); end
        vectors++; if (phy_data_rx_phy2link !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", phy_data_rx_phy2link); end
        hmc_res_n = 1'b1; P_RST_N = 1'b0; LXRXPS = 1'b0; ts1_locked = 1'b0;
        advance(2);
        vectors++; if (LXTXPS !== 1'b0 || FERR_N !== 1'b1 || phy_data_rx_phy2link !== '0)
            begin errors++; $display("FAIL prst_hold got lxtxps=%b ferr_n=%b exp 0/1", LXTXPS, FERR_N); end
        P_RST_N = 1'b1;
        step();
        vectors++; if (LXTXPS !== 1'b0) begin errors++; $display("FAIL wait_rxps_lxtxps got %b exp 0", LXTXPS); end
    endtask

    // Precondition: device in WAIT_RXPS with LXRXPS low. Upstream offers flits throughout to show they are ignored.
    task automatic test_init_sequence(input int lock_after);
        tx_flit_valid = 1'b1; tx_flit_data = rand_data();
        LXRXPS = 1'b1;
        step();
        vectors++; if (LXTXPS !== 1'b1) begin errors++; $display("FAIL lxtxps_rise got %b exp 1", LXTXPS); end
        for (int i = 0; i < T_NULL; i++) begin
            if (i > 0) step();
            vectors++; if (phy_data_rx_phy2link !== '0 || tx_flit_ready !== 1'b0)
                begin errors++; $display("FAIL null1 cyc=%0d got %h ready=%b exp 0", i, phy_data_rx_phy2link, tx_flit_ready); end
        end
        for (int k = 0; k < lock_after; k++) begin
            step();
            vectors++; if (phy_data_rx_phy2link !== exp_ts1(k))
                begin errors++; $display("FAIL ts1 k=%0d got %h exp %h", k, phy_data_rx_phy2link, exp_ts1(k)); end
        end
        ts1_locked = 1'b1;
        for (int i = 0; i < T_TRET; i++) begin
            step();
            ts1_locked = 1'b0;
            vectors++; if (phy_data_rx_phy2link !== '0 || LXTXPS !== 1'b1)
                begin errors++; $display("FAIL null2 cyc=%0d got %h lxtxps=%b exp 0/1", i, phy_data_rx_phy2link, LXTXPS); end
        end
        foreach (tret_q[c]) begin
            step();
            vectors++; if (phy_data_rx_phy2link !== tret_q[c] || init_done !== 1'b0)
                begin errors++; $display("FAIL tret c=%0d got %h exp %h", c, phy_data_rx_phy2link, tret_q[c]); end
        end
        step();
        vectors++; if (init_done !== 1'b1 || tx_flit_ready !== 1'b1)
            begin errors++; $display("FAIL active_flags got done=%b ready=%b exp 1/1", init_done, tx_flit_ready); end
        vectors++; if (phy_data_rx_phy2link !== '0)
            begin errors++; $display("FAIL active_first got %h exp 0", phy_data_rx_phy2link); end
        tx_flit_valid = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [DW-1:0] exp;
        tx_flit_valid = 1'b1; tx_flit_data = {(DW/8){8'hA5}};
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (phy_data_rx_phy2link !== {(DW/8){8'hA5}})
                begin errors++; $display("FAIL a5_beat i=%0d got %h exp a5..", i, phy_data_rx_phy2link); end
        end
        tx_flit_valid = 1'b0;
        step();
        vectors++; if (phy_data_rx_phy2link !== '0) begin errors++; $display("FAIL a5_idle got %h exp 0", phy_data_rx_phy2link); end
        for (int i = 0; i < 40; i++) begin
            tx_flit_valid = 1'($urandom_range(0, 1));
            tx_flit_data  = rand_data();
            exp = tx_flit_valid ? tx_flit_data : '0;
            step();
            vectors++; if (phy_data_rx_phy2link !== exp || tx_flit_ready !== 1'b1)
                begin errors++; $display("FAIL pass i=%0d got %h exp %h", i, phy_data_rx_phy2link, exp); end
        end
        tx_flit_valid = 1'b0;
    endtask

    task automatic test_p_rst();
        tx_flit_valid = 1'b1; tx_flit_data = rand_data();
        P_RST_N = 1'b0;
        step();
        P_RST_N = 1'b1; LXRXPS = 1'b0;
        vectors++; if (LXTXPS !== 1'b0 || FERR_N !== 1'b1 || tx_flit_ready !== 1'b0 || init_done !== 1'b0 || phy_data_rx_phy2link !== '0)
            begin errors++; $display("FAIL p_rst_active got lxtxps=%b ferr_n=%b ready=%b done=%b exp 0/1/0/0", LXTXPS, FERR_N, tx_flit_ready, init_done); end
        tx_flit_valid = 1'b0;
        step();
        vectors++; if (LXTXPS !== 1'b0) begin errors++; $display("FAIL p_rst_wait got %b exp 0", LXTXPS); end
    endtask

    task automatic test_tret_drop();
        LXRXPS = 1'b1;
        advance(T_NULL + 1);
        ts1_locked = 1'b1;
        step();
        ts1_locked = 1'b0;
        advance(T_TRET);
        vectors++; if (phy_data_rx_phy2link !== tret_q[0])
            begin errors++; $display("FAIL drop_tret0 got %h exp %h", phy_data_rx_phy2link, tret_q[0]); end
        LXRXPS = 1'b0;
        step();
        vectors++; if (LXTXPS !== 1'b0 || phy_data_rx_phy2link !== '0 || init_done !== 1'b0)
            begin errors++; $display("FAIL drop_next got lxtxps=%b data=%h exp 0/0", LXTXPS, phy_data_rx_phy2link); end
        advance(3);
        vectors++; if (LXTXPS !== 1'b0) begin errors++; $display("FAIL drop_hold got %b exp 0", LXTXPS); end
        test_init_sequence($urandom_range(1, 40));
    endtask

    task automatic reach_ts1_end();
        P_RST_N = 1'b1; LXRXPS = 1'b0; ts1_locked = 1'b0;
        step();
        LXRXPS = 1'b1;
        advance(T_NULL + 1);
        advance(TO - 1);
    endtask

    task automatic test_ts1_timeout();
        P_RST_N = 1'b0;
        step();
        reach_ts1_end();
        vectors++; if (FERR_N !== 1'b1 || phy_data_rx_phy2link !== exp_ts1(TO - 1))
            begin errors++; $display("FAIL to_last_ts1 got ferr_n=%b data=%h", FERR_N, phy_data_rx_phy2link); end
        step();
        vectors++; if (FERR_N !== 1'b0 || phy_data_rx_phy2link !== '0 || LXTXPS !== 1'b1)
            begin errors++; $display("FAIL to_error got ferr_n=%b lxtxps=%b exp 0/1", FERR_N, LXTXPS); end
        LXRXPS = 1'b0; ts1_locked = 1'b1;
        advance(5);
        vectors++; if (FERR_N !== 1'b0 || LXTXPS !== 1'b1)
            begin errors++; $display("FAIL err_sticky got ferr_n=%b lxtxps=%b exp 0/1", FERR_N, LXTXPS); end
        P_RST_N = 1'b0;
        step();
        vectors++; if (FERR_N !== 1'b1 || LXTXPS !== 1'b0)
            begin errors++; $display("FAIL err_clear got ferr_n=%b lxtxps=%b exp 1/0", FERR_N, LXTXPS); end
    endtask

    task automatic test_lock_at_timeout();
        reach_ts1_end();
        ts1_locked = 1'b1;
        step();
        ts1_locked = 1'b0;
        vectors++; if (FERR_N !== 1'b1 || LXTXPS !== 1'b1 || phy_data_rx_phy2link !== '0)
            begin errors++; $display("FAIL lock_wins got ferr_n=%b lxtxps=%b exp 1/1", FERR_N, LXTXPS); end
        advance(T_TRET);
        vectors++; if (phy_data_rx_phy2link !== tret_q[0])
            begin errors++; $display("FAIL lock_wins_tret got %h exp %h", phy_data_rx_phy2link, tret_q[0]); end
    endtask

    initial begin
        build_tret();
        test_reset();
        test_init_sequence($urandom_range(60, 140));
        test_passthrough();
        test_p_rst();
        test_tret_drop();
        test_ts1_timeout();
        test_lock_at_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
